mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle shift-and-add multiplier with its own sequencing FSM. Replaces
//  the combinational 8x8 multiply in the multiplier top level. Accepts a start
//  request, computes a*b over WIDTH cycles, and holds the product stable for the
//  7-segment display driver. Also reports busy and done to the top level.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//  clk      in   1        system clock; all state changes on rising edge
//  rst_n    in   1        asynchronous, active-low reset
//  start    in   1        level request; sampled only while in IDLE
//  a        in   WIDTH    multiplicand; sampled on the accepting edge only
//  b        in   WIDTH    multiplier; sampled on the accepting edge only
//  busy     out  1        high while in CALC
//  done     out  1        high for exactly one cycle (state DONE)
//  product  out  2*WIDTH  registered result; holds until the next DONE
// BEHAVIOUR
//  Reset (async assert, any state):
//   - state=IDLE; busy=0, done=0, product=0
//   - internal ma, mb, acc, cnt = 0
//   - deassertion takes effect on the next rising edge
//  FSM states: IDLE, CALC, DONE. All outputs come from registers.
//  IDLE:
//   - start=1 at edge E0: ma<=a, mb<=b, acc<=0, cnt<=0, go to CALC
//   - start=0: stay in IDLE
//  CALC (one iteration per edge):
//   - acc <= acc + (mb[0] ? (zero-extended ma) << cnt : 0)
//   - mb <= mb >> 1; cnt <= cnt+1
//   - on the edge with cnt==WIDTH-1: product <= final acc sum, go to DONE
//   - acc is 2*WIDTH bits, so no overflow is possible
//  DONE:
//   - done=1 for one cycle; go to IDLE on the next edge
//  Latency:
//   - fixed, independent of operand values; no early termination
//   - start accepted at E0; CALC iterations at E1..E_WIDTH
//   - done high in the cycle after E_WIDTH; back in IDLE after E_WIDTH+1
//   - for WIDTH=8: done goes high 9 edges after E0
//  start handling:
//   - ignored in CALC and DONE; a, b may change freely there
//   - start held high: new operation accepted at the first IDLE edge after DONE
//   - IDLE is always at least one cycle between operations
//  product:
//   - changes only on the CALC->DONE edge; stable during the next operation
//  Reset mid-CALC: operation is aborted, product=0, no done pulse.
//  busy and done are never high together.
// TESTING
//  1 a=0xFF, b=0xFF, start pulse:
//    busy high for 8 cycles; done 9 edges after accept; product=0xFE01
//  2 a=0x00, b=0xA5:
//    product=0x0000 with the same 9-edge latency; done pulses once
//  3 a=0x0C, b=0x0A accepted; during CALC: start=1, a=0x01, b=0x01:
//    product=0x0078; the second request is not latched
//  4 start held high, a=0x03, b=0x05:
//    done pulses every 10 cycles; product=0x000F; one IDLE cycle between runs
//  5 reset mid-CALC (prior product 0x0078), rst_n low at cycle 4 of CALC:
//    outputs go to 0 immediately; no done pulse; IDLE after release
//  6 random a/b sweep of 1000 operations:
//    product == a*b, done count == accept count, busy & done never both high

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier with its own IDLE/CALC/DONE sequencer.
// One partial product is added per clock; the product register holds between runs.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     ma_q;
  logic [WIDTH-1:0]     mb_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   addend_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last_iter_d;

  // Partial product for the current iteration and the running sum it produces
  always_comb begin
    addend_d    = '0;
    acc_d       = '0;
    last_iter_d = 1'b0;
    if (mb_q[0]) begin
      addend_d = {{WIDTH{1'b0}}, ma_q} << cnt_q;
    end else begin
      addend_d = '0;
    end
    acc_d       = acc_q + addend_d;
    last_iter_d = (cnt_q == CW'(WIDTH - 1));
  end

  // Sequencer, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ma_q    <= a;
            mb_q    <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          // Fixed WIDTH iterations regardless of operand values
          if (last_iter_d) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            state_q   <= CALC;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and random-operand checks for mult_seq_ctrl (WIDTH=8).
module tb_mult_seq_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks;
  int failures;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: start pulse at the accept edge, optional start/operand noise during CALC.
  // Latency counts edges from the accept edge (as edge 1) to the edge that raises done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p, input bit noise, input string tag);
    int edges;
    int busy_cnt;
    int overlap;
    a = av; b = bv; start = 1'b1;
    tick();
    edges = 1; busy_cnt = 0; overlap = 0;
    start = 1'b0;
    if (noise) begin
      start = 1'b1; a = 8'h01; b = 8'h01;
    end
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      tick();
      edges++;
    end
    if (busy && done) overlap++;
    chk({tag, "_latency"}, edges, 32'd9);
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    chk({tag, "_product"}, {16'd0, product}, {16'd0, exp_p});
    chk({tag, "_busy_done_overlap"}, overlap, 32'd0);
    start = 1'b0;
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    if (noise) begin
      tick();
      chk({tag, "_no_second_accept"}, {31'd0, busy}, 32'd0);
      chk({tag, "_product_held"}, {16'd0, product}, {16'd0, exp_p});
    end
  endtask

  initial begin
    int done_pos[$];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [15:0]  exp_p;
    int nodone;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "t1");
    run_op(8'h00, 8'hA5, 16'h0000, 1'b0, "t2");
    run_op(8'h0C, 8'h0A, 16'h0078, 1'b1, "t3");

    // Reset during the 4th CALC cycle aborts the run
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    chk("t5_product_before_rst", {16'd0, product}, 32'h0078);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_rst_product", {16'd0, product}, 32'd0);
    tick();
    rst_n = 1'b1;
    nodone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) nodone++;
    end
    chk("t5_no_done_after_rst", nodone, 32'd0);

    // start held high: back-to-back runs every 10 cycles with an IDLE gap
    a = 8'h03; b = 8'h05; start = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (done) done_pos.push_back(c);
    end
    chk("t4_done_pulses", done_pos.size(), 32'd3);
    if (done_pos.size() >= 3) begin
      chk("t4_period_a", done_pos[1] - done_pos[0], 32'd10);
      chk("t4_period_b", done_pos[2] - done_pos[1], 32'd10);
    end
    chk("t4_product", {16'd0, product}, 32'h000F);
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_idle", {31'd0, busy}, 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      exp_p = 16'(ra) * 16'(rb);
      run_op(ra, rb, exp_p, 1'b0, "t6");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
